handshake_skid_buffer: RTL
==========================

Name: handshake_skid_buffer

Overview:
- Full-throughput valid/ready register slice placed directly upstream of the handshake receiver stage.
- Accepts bytes from the producer and presents them to the receiver over a registered valid/data interface.
- Absorbs the receiver's random stalls using a 2-entry skid buffer.
- Upstream ready is driven from a flop, with no combinational path from ready_i, so the slice breaks both forward and backward timing paths.

Parameters:
- DATA_W, 8, width of the data payload in bits.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_i  input  1  upstream data valid.
- data_i  input  DATA_W  upstream data.
- ready_o  output  1  to upstream; registered.
- valid_o  output  1  to downstream receiver; registered.
- data_o  output  DATA_W  to downstream receiver; registered.
- ready_i  input  1  from downstream receiver (may toggle every cycle).
- count_o  output  2  current occupancy, 0..2.

Behaviour:
- Interface decided: one clock (clk); reset rst is synchronous and active-high.
- Transfer definitions: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- Reset (rst=1 at a clk edge) forces the following, regardless of other inputs:
  - state=EMPTY, valid_o=0, data_o=0, ready_o=0, count_o=0.
  - Skid register cleared to 0.
- First edge with rst=0 sets ready_o=1.
- Storage: main register (drives data_o/valid_o) and skid register.
- States:
  - EMPTY: count 0, valid_o=0.
  - BUSY: count 1, main register valid.
  - FULL: count 2, main and skid registers valid.
- Transitions:
  - EMPTY, in_fire: main<=data_i; go to BUSY.
  - BUSY, in_fire & out_fire: main<=data_i; stay BUSY.
  - BUSY, in_fire & !out_fire: skid<=data_i; go to FULL.
  - BUSY, !in_fire & out_fire: go to EMPTY.
  - FULL, out_fire: main<=skid; go to BUSY. in_fire is impossible because ready_o=0.
  - No fire in any state: hold all registers.
- ready_o register: next value = (next_state != FULL).
  - ready_o is low exactly for the cycles the slice is FULL.
  - The upstream-visible stall lags by zero cycles. The skid entry absorbs the one beat the producer commits while ready_o is still high.
- Latency: data accepted on in_fire at edge N appears on data_o with valid_o=1 after edge N (1 cycle), when the slice was EMPTY or draining.
- Throughput: one transfer per cycle sustained while ready_i=1.
- Ordering: strict FIFO. No loss, no duplication.
- data_o is stable while valid_o=1 and ready_i=0.
- valid_o never drops without an out_fire.
- count_o equals the state encoding (0/1/2).
- valid_i/data_i while ready_o=0 are ignored and never sampled.
- Reset mid-operation: in-flight entries are discarded; no partial output; outputs take reset values at that edge.
- No X propagation: data registers load only on the fire conditions above.

Decomposition:
- Shared package handshake_pkg:
  - DATA_W default (8).
  - State encoding localparams ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2. State encoding doubles as count_o.
- Single flat module; no sub-module needed.
- Next-state/next-ready logic stays in one combinational block; registers in one sequential block.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, then 0 -> during reset ready_o=0, valid_o=0, count_o=0, data_o=0; one edge after release ready_o=1.
- Streaming: ready_i=1, valid_i=1, data_i=0x00..0x0F on consecutive cycles -> data_o=0x00..0x0F one per cycle starting 1 cycle after first in_fire; count_o=1 throughout; ready_o never drops.
- Skid fill:
  - Stimulus: send 0xA1 with ready_i=1; drop ready_i to 0; send 0xA2 and offer 0xA3.
  - Response: count_o reaches 2 and ready_o=0 the edge after 0xA2 accepted; 0xA3 held upstream; data_o=0xA1 stable while ready_i=0.
  - Release: raising ready_i outputs 0xA1, 0xA2, 0xA3 in order with no gaps or duplicates.
- Drain to empty: BUSY holding 0x5C, valid_i=0, ready_i=1 -> 0x5C transferred, next cycle valid_o=0, count_o=0, ready_o=1.
- Random: 10,000 cycles with ready_i and valid_i each random 50%, incrementing data_i -> scoreboard sees strictly incrementing output with no loss or duplication, data_o stable under stall, and count_o matching the model every cycle.
- Reset mid-operation: in FULL holding 0x11/0x22, assert rst for 1 cycle -> valid_o=0, count_o=0 after that edge; 0x11/0x22 never emitted; next accepted byte 0x33 is the first output.

Source files
------------

// File: rtl/handshake_skid_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : handshake_pkg
// Purpose  : Shared width default and state encoding for the skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
package handshake_pkg;

    localparam int DATA_W = 8;

    // State encoding doubles as the occupancy count
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/handshake_skid_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : handshake_skid_buffer_if
// Purpose  : Upstream and downstream valid/ready signals of the skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface handshake_skid_buffer_if #(
    parameter int DATA_W = handshake_pkg::DATA_W
);
    logic              valid_i;
    logic [DATA_W-1:0] data_i;
    logic              ready_o;
    logic              valid_o;
    logic [DATA_W-1:0] data_o;
    logic              ready_i;
    logic [1:0]        count_o;

    // master: the environment around the slice (producer + receiver)
    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, count_o
    );

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, count_o
    );
endinterface
`default_nettype wire

// File: rtl/handshake_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : handshake_skid_buffer
// Purpose  : Full-throughput register slice with a 2-entry skid buffer;
//            registered ready upstream, registered valid/data downstream.
// Revision : 1.0 - initial release
// ============================================================================
module handshake_skid_buffer
    import handshake_pkg::*;
#(
    parameter int DATA_W = handshake_pkg::DATA_W
) (
    input  wire logic               clk,
    input  wire logic               rst,
    handshake_skid_buffer_if.slave  bus
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              r_ready;
    logic              w_ready_nxt;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_load_main;
    logic              w_main_from_skid;
    logic              w_load_skid;

    assign w_in_fire  = bus.valid_i & r_ready;
    assign w_out_fire = (r_state != ST_EMPTY) & bus.ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_ready <= 1'b0;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= w_ready_nxt;
            if (w_load_main) begin
                r_main <= w_main_from_skid ? r_skid : bus.data_i;
            end
            if (w_load_skid) begin
                r_skid <= bus.data_i;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_load_main = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main = 1'b1;
                end else if (w_in_fire) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = ST_FULL;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // ready_o is low here, so only the drain path can occur
                if (w_out_fire) begin
                    w_load_main      = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_state_nxt      = ST_BUSY;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        w_ready_nxt = (w_state_nxt != ST_FULL);
    end

    always_comb begin
        bus.ready_o = r_ready;
        bus.valid_o = (r_state != ST_EMPTY);
        bus.data_o  = r_main;
        bus.count_o = r_state;
    end

endmodule
`default_nettype wire
